// File: rtl/rf_pkg.sv
// Shared types for the register_file slice.
// Write-port opcode encodings and the op_t typedef.
package rf_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

endpackage

// File: rtl/register_file_if.sv
// Write/read bus of register_file.
// The master drives the write and read requests; the slave returns data and flags.
interface register_file_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    import rf_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);

    logic              En;
    logic              WrEn;
    op_t               Op;
    logic [ADDR_W-1:0] WrAddr;
    logic [WIDTH-1:0]  D;
    logic [ADDR_W-1:0] RdAddrA;
    logic [ADDR_W-1:0] RdAddrB;
    logic [WIDTH-1:0]  QoutA;
    logic [WIDTH-1:0]  QoutB;
    logic              Carry;
    logic              Zero;

    modport master (
        output En, WrEn, Op, WrAddr, D, RdAddrA, RdAddrB,
        input  QoutA, QoutB, Carry, Zero
    );

    modport slave (
        input  En, WrEn, Op, WrAddr, D, RdAddrA, RdAddrB,
        output QoutA, QoutB, Carry, Zero
    );

endinterface

// File: rtl/rf_next_val.sv
// Next-value datapath for one register: {carry/borrow, result}.
// Shared by the write port and the optional read bypass.
module rf_next_val
    import rf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] d,
    input  op_t              op,
    output logic [WIDTH:0]   res
);

    always_comb begin
        res = '0;
        unique case (1'b1)
            op == OP_LOAD: res = {1'b0, d};
            op == OP_INC:  res = {1'b0, cur} + (WIDTH+1)'(1);
            op == OP_DEC:  res = {1'b0, cur} - (WIDTH+1)'(1);
            op == OP_CLR:  res = '0;
            default:       res = '0;
        endcase
    end

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register bank: one load/inc/dec/clr write port, two async reads.
// Define RF_BYPASS_EN to forward a committing write onto matching read ports.
module register_file
    import rf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic             CLK,
    input logic             CLR_n,
    register_file_if.slave  rf
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             commit;
    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   nv;

    // Out-of-range write addresses are silently dropped.
    always_comb begin
        commit = rf.En && rf.WrEn && (int'(rf.WrAddr) < DEPTH);
        cur    = '0;
        if (commit) cur = regs[rf.WrAddr];
    end

    rf_next_val #(.WIDTH(WIDTH)) u_next_val (
        .cur (cur),
        .d   (rf.D),
        .op  (rf.Op),
        .res (nv)
    );

    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            rf.Carry <= 1'b0;
            rf.Zero  <= 1'b0;
        end else if (commit) begin
            regs[rf.WrAddr] <= nv[WIDTH-1:0];
            rf.Carry        <= nv[WIDTH];
            rf.Zero         <= (nv[WIDTH-1:0] == '0);
        end
    end

    always_comb begin
        rf.QoutA = '0;
        rf.QoutB = '0;
        if (int'(rf.RdAddrA) < DEPTH) rf.QoutA = regs[rf.RdAddrA];
        if (int'(rf.RdAddrB) < DEPTH) rf.QoutB = regs[rf.RdAddrB];
`ifdef RF_BYPASS_EN
        if (commit && rf.RdAddrA == rf.WrAddr) rf.QoutA = nv[WIDTH-1:0];
        if (commit && rf.RdAddrB == rf.WrAddr) rf.QoutB = nv[WIDTH-1:0];
`else
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: DEPTH=4 main instance plus a DEPTH=3
// instance for out-of-range addressing.
module tb_register_file;
    import rf_pkg::*;

    logic clk;
    logic clr_n;
    int   n_cmp;
    int   n_bad;

    register_file_if #(.WIDTH(8), .DEPTH(4)) i0 ();
    register_file_if #(.WIDTH(8), .DEPTH(3)) i3 ();

    register_file #(.WIDTH(8), .DEPTH(4)) u0 (
        .CLK   (clk),
        .CLR_n (clr_n),
        .rf    (i0)
    );

    register_file #(.WIDTH(8), .DEPTH(3)) u3 (
        .CLK   (clk),
        .CLR_n (clr_n),
        .rf    (i3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [1:0] a, input op_t op, input logic [7:0] d);
        i0.En     = 1'b1;
        i0.WrEn   = 1'b1;
        i0.WrAddr = a;
        i0.Op     = op;
        i0.D      = d;
        step();
        i0.WrEn   = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] a, input op_t op, input logic [7:0] d);
        i3.En     = 1'b1;
        i3.WrEn   = 1'b1;
        i3.WrAddr = a;
        i3.Op     = op;
        i3.D      = d;
        step();
        i3.WrEn   = 1'b0;
    endtask

    task automatic rd0(input string tag, input logic [1:0] a,
                       input logic [7:0] exp);
        i0.RdAddrA = a;
        #1;
        check(tag, 32'(i0.QoutA), 32'(exp));
    endtask

    task automatic flags0(input string tag, input logic c, input logic z);
        check({tag, "_carry"}, 32'(i0.Carry), 32'(c));
        check({tag, "_zero"}, 32'(i0.Zero), 32'(z));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clr_n = 1'b0;
        i0.En = 1'b0; i0.WrEn = 1'b0; i0.Op = OP_LOAD;
        i0.WrAddr = '0; i0.D = '0; i0.RdAddrA = '0; i0.RdAddrB = '0;
        i3.En = 1'b0; i3.WrEn = 1'b0; i3.Op = OP_LOAD;
        i3.WrAddr = '0; i3.D = '0; i3.RdAddrA = '0; i3.RdAddrB = '0;

        step();
        rd0("rst_r0", 2'd0, 8'h00);
        rd0("rst_r3", 2'd3, 8'h00);
        flags0("rst", 1'b0, 1'b0);

        // Preload, then reset while a write is requested.
        clr_n = 1'b1;
        wr0(2'd0, OP_LOAD, 8'h5A);
        rd0("pre_r0", 2'd0, 8'h5A);
        wr0(2'd1, OP_CLR, 8'h00);
        flags0("pre_clr", 1'b0, 1'b1);
        clr_n = 1'b0;
        i0.En = 1'b1; i0.WrEn = 1'b1; i0.WrAddr = 2'd1;
        i0.Op = OP_LOAD; i0.D = 8'h33;
        step();
        clr_n = 1'b1;
        i0.WrEn = 1'b0;
        rd0("rst2_r0", 2'd0, 8'h00);
        rd0("rst2_r1", 2'd1, 8'h00);
        flags0("rst2", 1'b0, 1'b0);

        // Load and read on both ports.
        wr0(2'd1, OP_LOAD, 8'h05);
        wr0(2'd2, OP_LOAD, 8'hF0);
        i0.RdAddrA = 2'd1;
        i0.RdAddrB = 2'd2;
        #1;
        check("ld_qa", 32'(i0.QoutA), 32'h05);
        check("ld_qb", 32'(i0.QoutB), 32'hF0);
        flags0("ld", 1'b0, 1'b0);
        i0.RdAddrB = 2'd1;
        #1;
        check("same_addr_qb", 32'(i0.QoutB), 32'h05);

        // Increment wrap, then gating with flags set.
        wr0(2'd3, OP_LOAD, 8'hFF);
        flags0("ldff", 1'b0, 1'b0);
        wr0(2'd3, OP_INC, 8'h00);
        rd0("inc_r3", 2'd3, 8'h00);
        flags0("inc", 1'b1, 1'b1);

        i0.En = 1'b0; i0.WrEn = 1'b1; i0.WrAddr = 2'd0;
        i0.Op = OP_LOAD; i0.D = 8'h77;
        step();
        rd0("gate_en_r0", 2'd0, 8'h00);
        flags0("gate_en", 1'b1, 1'b1);
        i0.En = 1'b1; i0.WrEn = 1'b0; i0.WrAddr = 2'd3;
        step();
        rd0("gate_wr_r3", 2'd3, 8'h00);
        flags0("gate_wr", 1'b1, 1'b1);

        wr0(2'd3, OP_DEC, 8'h00);
        rd0("dec1_r3", 2'd3, 8'hFF);
        flags0("dec1", 1'b1, 1'b0);
        wr0(2'd3, OP_DEC, 8'h00);
        rd0("dec2_r3", 2'd3, 8'hFE);
        flags0("dec2", 1'b0, 1'b0);

        // Same-cycle read of the register being written.
        i0.RdAddrA = 2'd1;
        i0.RdAddrB = 2'd2;
        i0.En = 1'b1; i0.WrEn = 1'b1; i0.WrAddr = 2'd1;
        i0.Op = OP_LOAD; i0.D = 8'h09;
        #1;
`ifdef RF_BYPASS_EN
        check("rw_before_qa", 32'(i0.QoutA), 32'h09);
`else
        check("rw_before_qa", 32'(i0.QoutA), 32'h05);
`endif
        check("rw_before_qb", 32'(i0.QoutB), 32'hF0);
        step();
        i0.WrEn = 1'b0;
        #1;
        check("rw_after_qa", 32'(i0.QoutA), 32'h09);

        // CLR op leaves other registers alone.
        wr0(2'd2, OP_CLR, 8'hAA);
        rd0("clr_r2", 2'd2, 8'h00);
        flags0("clr", 1'b0, 1'b1);
        rd0("clr_r0", 2'd0, 8'h00);
        rd0("clr_r1", 2'd1, 8'h09);
        rd0("clr_r3", 2'd3, 8'hFE);

        // DEPTH=3: address 3 is out of range on both write and read.
        wr3(2'd2, OP_LOAD, 8'h42);
        wr3(2'd1, OP_CLR, 8'h00);
        i3.En = 1'b1; i3.WrEn = 1'b1; i3.WrAddr = 2'd3;
        i3.Op = OP_LOAD; i3.D = 8'h11;
        step();
        i3.WrEn = 1'b0;
        i3.RdAddrA = 2'd3;
        i3.RdAddrB = 2'd2;
        #1;
        check("d3_rd3", 32'(i3.QoutA), 32'h00);
        check("d3_r2", 32'(i3.QoutB), 32'h42);
        check("d3_zero", 32'(i3.Zero), 32'h1);
        check("d3_carry", 32'(i3.Carry), 32'h0);
        wr3(2'd0, OP_DEC, 8'h00);
        i3.RdAddrA = 2'd0;
        #1;
        check("d3_dec_r0", 32'(i3.QoutA), 32'hFF);
        check("d3_dec_carry", 32'(i3.Carry), 32'h1);
        check("d3_dec_zero", 32'(i3.Zero), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
